// File: rtl/press_decoder_pkg.sv
// Shared constants for the press decoder: FSM state encoding and event indices.
package press_decoder_pkg;

    // FSM state encoding (3-bit)
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PRESS1    = 3'd1;
    localparam logic [2:0] ST_LONG_HOLD = 3'd2;
    localparam logic [2:0] ST_GAP       = 3'd3;
    localparam logic [2:0] ST_PRESS2    = 3'd4;

    // Event codes: bit positions inside the registered pulse vector
    localparam int EV_NUM   = 3;
    localparam int EV_SHORT = 0;
    localparam int EV_LONG  = 1;
    localparam int EV_DBL   = 2;

endpackage

// File: rtl/press_decoder_edge_det.sv
// Rise/fall detector on the debounced level. The history register resets
// to 1 so a button already held at reset produces no rise until re-pressed.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    // One-cycle history of the input level
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= 1'b1;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/press_decoder.sv
// Classifies debounced button activity into short press, long press and
// double click, each reported as a registered one-cycle pulse, and keeps a
// wrapping count of reported events.
module press_decoder
    import press_decoder_pkg::*;
#(
    parameter int              CNT_W        = 8,
    parameter logic [CNT_W-1:0] LONG_TICKS   = CNT_W'(50),
    parameter logic [CNT_W-1:0] DCLICK_TICKS = CNT_W'(25)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       db,
    output logic       short_p,
    output logic       long_p,
    output logic       dbl_p,
    output logic       busy,
    output logic [7:0] event_cnt
);

    // Terminal tick values at which the hold / gap windows expire
    localparam logic [CNT_W-1:0] LONG_LAST   = LONG_TICKS - CNT_W'(1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = DCLICK_TICKS - CNT_W'(1);

    logic              rise;
    logic              fall;
    logic [2:0]        state_reg;
    logic [2:0]        state_next;
    logic [CNT_W-1:0]  tick_reg;
    logic [CNT_W-1:0]  tick_next;
    logic [EV_NUM-1:0] ev_reg;
    logic [EV_NUM-1:0] ev_next;
    logic              busy_reg;
    logic [7:0]        cnt_reg;

    edge_det u_edge_det (
        .clk  (clk),
        .rst  (rst),
        .d    (db),
        .rise (rise),
        .fall (fall)
    );

    // State register, tick counter, registered pulses and event counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            tick_reg  <= '0;
            ev_reg    <= '0;
            busy_reg  <= 1'b0;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            tick_reg  <= tick_next;
            ev_reg    <= ev_next;
            busy_reg  <= (state_next != ST_IDLE);
            if (|ev_next) begin
                cnt_reg <= cnt_reg + 8'd1;
            end
        end
    end

    // Next-state and tick logic. While pressed, the first low sample is
    // always a fall (db_q is 1 throughout), so fall stands in for db==0.
    always_comb begin
        state_next = state_reg;
        tick_next  = tick_reg;
        case (state_reg)
            ST_IDLE: begin
                if (rise) begin
                    state_next = ST_PRESS1;
                    tick_next  = '0;
                end
            end
            ST_PRESS1: begin
                if (fall) begin
                    state_next = ST_GAP;
                    tick_next  = '0;
                end else if (tick_reg == LONG_LAST) begin
                    state_next = ST_LONG_HOLD;
                end else begin
                    tick_next = tick_reg + CNT_W'(1);
                end
            end
            ST_LONG_HOLD: begin
                if (fall) begin
                    state_next = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (rise) begin
                    state_next = ST_PRESS2;
                end else if (tick_reg == DCLICK_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    tick_next = tick_reg + CNT_W'(1);
                end
            end
            ST_PRESS2: begin
                if (fall) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                tick_next  = '0;
            end
        endcase
    end

    // Pulse decision for this edge; release beats long, rise beats short
    always_comb begin
        ev_next = '0;
        case (state_reg)
            ST_PRESS1: begin
                if (!fall && (tick_reg == LONG_LAST)) begin
                    ev_next[EV_LONG] = 1'b1;
                end
            end
            ST_GAP: begin
                if (rise) begin
                    ev_next[EV_DBL] = 1'b1;
                end else if (tick_reg == DCLICK_LAST) begin
                    ev_next[EV_SHORT] = 1'b1;
                end
            end
            default: begin
                ev_next = '0;
            end
        endcase
    end

    assign short_p   = ev_reg[EV_SHORT];
    assign long_p    = ev_reg[EV_LONG];
    assign dbl_p     = ev_reg[EV_DBL];
    assign busy      = busy_reg;
    assign event_cnt = cnt_reg;

endmodule

// File: tb/tb_press_decoder.sv
// Bench for press_decoder: waveforms are built as run lengths of db, and the
// expected pulses/busy/count are derived from those run lengths directly.
module tb_press_decoder;

    localparam int LONG_T = 8;
    localparam int DCL_T  = 4;
    localparam int EV_S   = 1;
    localparam int EV_L   = 2;
    localparam int EV_D   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       db  = 1'b0;
    logic       short_p;
    logic       long_p;
    logic       dbl_p;
    logic       busy;
    logic [7:0] event_cnt;

    int tests = 0;
    int fails = 0;

    bit wave[$];
    int exp_ev[$];
    bit exp_busy[$];

    press_decoder #(
        .CNT_W        (8),
        .LONG_TICKS   (8'd8),
        .DCLICK_TICKS (8'd4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .db        (db),
        .short_p   (short_p),
        .long_p    (long_p),
        .dbl_p     (dbl_p),
        .busy      (busy),
        .event_cnt (event_cnt)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic add(input bit v, input int len);
        for (int k = 0; k < len; k++) wave.push_back(v);
    endtask

    function automatic int runlen(input int start, input bit v);
        int k = 0;
        while (start + k < wave.size() && wave[start + k] == v) k++;
        return k;
    endfunction

    // Sample n is db at edge n. A rise starts a press; press length, gap
    // length and second-press length decide the event and when it fires.
    task automatic build_model();
        int n;
        int i;
        int e;
        int h;
        int f;
        int g;
        int stop;
        n = wave.size();
        exp_ev.delete();
        exp_busy.delete();
        for (int k = 0; k < n; k++) begin
            exp_ev.push_back(0);
            exp_busy.push_back(1'b0);
        end
        i = runlen(0, 1'b1);   // level held through reset never counts
        while (i < n) begin
            i += runlen(i, 1'b0);
            if (i >= n) break;
            e = i;
            h = runlen(e, 1'b1);
            if (h >= LONG_T + 1) begin
                exp_ev[e + LONG_T] = EV_L;
                stop = e + h;
            end else begin
                f = e + h;
                g = runlen(f, 1'b0);
                if (f >= n) begin
                    stop = n;
                end else if (g <= DCL_T && f + g < n) begin
                    exp_ev[f + g] = EV_D;
                    stop = f + g + runlen(f + g, 1'b1);
                end else if (g > DCL_T) begin
                    exp_ev[f + DCL_T] = EV_S;
                    stop = f + DCL_T;
                end else begin
                    stop = n;
                end
            end
            for (int k = e; k < stop && k < n; k++) exp_busy[k] = 1'b1;
            i = stop;
        end
    endtask

    // Reset, then drive the stored waveform and compare every cycle
    task automatic play(input string tag);
        int cnt = 0;
        int nev = 0;
        logic [2:0] expv;
        build_model();
        @(negedge clk);
        rst = 1'b1;
        db  = wave[0];
        @(posedge clk);
        @(posedge clk);
        #1;
        chk({tag, "_rst_pulses"}, {29'd0, short_p, long_p, dbl_p}, 32'd0);
        chk({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rst_cnt"}, {24'd0, event_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < wave.size(); k++) begin
            db = wave[k];
            @(posedge clk);
            #1;
            if (exp_ev[k] != 0) begin
                cnt = (cnt + 1) % 256;
                nev++;
            end
            expv = {exp_ev[k] == EV_S, exp_ev[k] == EV_L, exp_ev[k] == EV_D};
            chk({tag, "_pulses"}, {29'd0, short_p, long_p, dbl_p}, {29'd0, expv});
            chk({tag, "_onehot"}, {31'd0, $onehot0({short_p, long_p, dbl_p})}, 32'd1);
            chk({tag, "_busy"}, {31'd0, busy}, {31'd0, exp_busy[k]});
            chk({tag, "_cnt"}, {24'd0, event_cnt}, cnt);
            @(negedge clk);
        end
        $display("[TB] scenario %s: %0d cycles, %0d events, event_cnt=%0d", tag, wave.size(), nev, event_cnt);
    endtask

    initial begin
        // 1: short press, short_p 4 cycles after fall
        wave.delete(); add(0, 2); add(1, 3); add(0, 8);
        play("s1_short");
        chk("s1_final_cnt", {24'd0, event_cnt}, 32'd1);

        // 2: long hold, long_p 8 cycles after rise, nothing on release
        wave.delete(); add(0, 2); add(1, 12); add(0, 8);
        play("s2_long");
        chk("s2_final_cnt", {24'd0, event_cnt}, 32'd1);

        // 3: double click
        wave.delete(); add(0, 2); add(1, 2); add(0, 2); add(1, 2); add(0, 8);
        play("s3_dbl");
        chk("s3_final_cnt", {24'd0, event_cnt}, 32'd1);

        // 4: rise exactly at gap limit, then release exactly at long limit
        wave.delete(); add(0, 2); add(1, 2); add(0, 4); add(1, 2); add(0, 6);
        add(1, 8); add(0, 8);
        play("s4_bound");
        chk("s4_final_cnt", {24'd0, event_cnt}, 32'd2);

        // 5a: held through reset, only a re-press counts
        wave.delete(); add(1, 6); add(0, 2); add(1, 2); add(0, 8);
        play("s5_held");
        chk("s5_final_cnt", {24'd0, event_cnt}, 32'd1);

        // 5b: reset in the middle of a press
        wave.delete(); add(0, 2); add(1, 2); add(0, 6); add(1, 3);
        play("s5_mid");
        @(negedge clk);
        rst = 1'b1;
        db  = 1'b1;
        @(posedge clk);
        #1;
        chk("s5_midrst_busy", {31'd0, busy}, 32'd0);
        chk("s5_midrst_cnt", {24'd0, event_cnt}, 32'd0);
        chk("s5_midrst_pulses", {29'd0, short_p, long_p, dbl_p}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            chk("s5_after_pulses", {29'd0, short_p, long_p, dbl_p}, 32'd0);
            chk("s5_after_busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
        end
        db = 1'b0;
        @(negedge clk);
        db = 1'b1;
        @(posedge clk);
        #1;
        chk("s5_repress_busy", {31'd0, busy}, 32'd1);
        $display("[TB] scenario s5_midrst: reset while pressed, event_cnt=%0d", event_cnt);

        // 6: 256 short presses wrap the counter
        wave.delete(); add(0, 2);
        for (int p = 0; p < 256; p++) begin
            add(1, 2);
            add(0, 5);
        end
        play("s6_wrap");
        chk("s6_final_cnt", {24'd0, event_cnt}, 32'd0);

        // Random run-length waveforms concentrated around the thresholds
        for (int r = 0; r < 6; r++) begin
            wave.delete();
            add(0, 2);
            for (int q = 0; q < 40; q++) begin
                add(q[0] ? 1'b0 : 1'b1, $urandom_range(1, 12));
            end
            add(0, 10);
            play($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
